// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampled mode-0 SPI slave.
package spi_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // SPI mode 0: SCLK idles low, data sampled on the rising edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous pin with rise/fall strobes.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   prime_q;

  // Strobes stay masked until the chain and history hold real pin samples, so a pin that
  // already differs from RESET_VAL when reset releases does not look like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q  <= sync_q[SYNC_STAGES-1];
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = prime_q[SYNC_STAGES] & level & ~prev_q;
  assign fall  = prime_q[SYNC_STAGES] & ~level & prev_q;

endmodule

// File: rtl/spi_slave_sclk_rx.sv
// Mode-0 SPI slave running on the system clock; oversamples SCLK, SS and MOSI pins.
module spi_slave_sclk_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SCLK,
  input  logic                  SS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] TXDATA,
  input  logic                  TXLOAD,
  output logic                  TXREADY,
  output logic [DATA_WIDTH-1:0] RXDATA,
  output logic                  RXVALID,
  output logic                  BUSY
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic sample_stb, shift_stb;
  logic unused_sync_outputs;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (CPOL)
  ) u_sclk_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (SCLK),
    .level(sclk_level),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_ss_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (SS),
    .level(ss_level),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_mosi_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (MOSI),
    .level(mosi_level),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  assign unused_sync_outputs = ^{sclk_level, mosi_rise, mosi_fall};

  // Leading edge samples MOSI, trailing edge advances MISO.
  assign sample_stb = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
  assign shift_stb  = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;

  spi_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] rxdata_q, rxdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hold_full_q, hold_full_d;
  logic                  reload_q, reload_d;
  logic                  rxvalid_q, rxvalid_d;
  logic                  busy_q;
  logic                  tx_take;
  logic [DATA_WIDTH-1:0] tx_next;

  // An empty holding register sends 0x00 (underrun).
  assign tx_next = hold_full_q ? hold_q : '0;

  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rxdata_d    = rxdata_q;
    cnt_d       = cnt_q;
    reload_d    = reload_q;
    rxvalid_d   = 1'b0;
    tx_take     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        reload_d = 1'b0;
        if (ss_fall) begin
          state_d    = ST_ACTIVE;
          tx_shift_d = tx_next;
          rx_shift_d = '0;
          tx_take    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // SS release outranks any SCLK edge seen in the same cycle.
        if (ss_rise) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          reload_d = 1'b0;
        end else if (sample_stb) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_level};
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            rxdata_d  = rx_shift_d;
            rxvalid_d = 1'b1;
            cnt_d     = '0;
            reload_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (shift_stb) begin
          if (reload_q) begin
            tx_shift_d = tx_next;
            tx_take    = 1'b1;
            reload_d   = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load is only accepted into an empty register, so a same-cycle transfer of a full
    // register takes the old value and the new write is dropped.
    if (TXLOAD && !hold_full_q) begin
      hold_d      = TXDATA;
      hold_full_d = 1'b1;
    end else if (tx_take) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rxdata_q    <= '0;
      cnt_q       <= '0;
      reload_q    <= 1'b0;
      rxvalid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rxdata_q    <= rxdata_d;
      cnt_q       <= cnt_d;
      reload_q    <= reload_d;
      rxvalid_q   <= rxvalid_d;
      busy_q      <= ~ss_level;
    end
  end

  assign MISO    = (state_q == ST_ACTIVE) && tx_shift_q[DATA_WIDTH-1];
  assign TXREADY = ~hold_full_q;
  assign RXDATA  = rxdata_q;
  assign RXVALID = rxvalid_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_spi_slave_sclk_rx.sv
// Bench for spi_slave_sclk_rx: directed vector table, corner sequences, random transfers.
module tb_spi_slave_sclk_rx;

  localparam int HALF = 8;  // SCLK half period in CLK cycles (>= SYNC_STAGES+2)
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst, sclk, ss, mosi, miso, txload, txready, rxvalid, busy;
  logic [7:0] txdata, rxdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_slave_sclk_rx #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .SCLK   (sclk),
    .SS     (ss),
    .MOSI   (mosi),
    .MISO   (miso),
    .TXDATA (txdata),
    .TXLOAD (txload),
    .TXREADY(txready),
    .RXDATA (rxdata),
    .RXVALID(rxvalid),
    .BUSY   (busy)
  );

  // Every high RXVALID cycle is logged, so a stretched pulse shows up as an extra byte.
  logic [7:0] rx_got[$];
  always @(negedge clk) if (rxvalid) rx_got.push_back(rxdata);

  logic [7:0] mosi_b[4];
  logic [7:0] miso_b[4];
  logic [7:0] rel_val[4];
  bit         rel_en[4];

  typedef struct {
    int         nbits;
    logic [7:0] mosi;
    bit         pre_en;
    logic [7:0] pre;
    bit         pre2_en;
    logic [7:0] pre2;
    int         exp_n;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    txdata = v;
    txload = 1'b1;
    wait_clk(1);
    txload = 1'b0;
  endtask

  // Mode-0 master: data set up before each rise, MISO captured just before the rise.
  task automatic spi_xfer(input int nbits);
    for (int i = 0; i < 4; i++) miso_b[i] = 8'h00;
    ss = 1'b0;
    wait_clk(HALF);
    check("busy_active", busy, 1);
    for (int b = 0; b < nbits; b++) begin
      int byi;
      int bi;
      byi = b / 8;
      bi  = 7 - (b % 8);
      mosi = mosi_b[byi][bi];
      wait_clk(HALF);
      miso_b[byi][bi] = miso;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
      if ((b % 8) == 0 && rel_en[byi]) begin
        check("txready_reload", txready, 1);
        do_load(rel_val[byi]);
      end
    end
    wait_clk(HALF);
    ss = 1'b1;
    wait_clk(SYNC + 2);
    check("miso_idle", miso, 0);
    wait_clk(HALF);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    bit         hf;
    logic [7:0] hv;

    rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; txload = 1'b0; txdata = 8'h00;
    for (int k = 0; k < 4; k++) begin
      rel_en[k] = 1'b0; rel_val[k] = 8'h00; mosi_b[k] = 8'h00;
    end

    // Reset state
    wait_clk(3);
    check("rst_miso", miso, 0);
    check("rst_rxvalid", rxvalid, 0);
    check("rst_txready", txready, 1);
    check("rst_busy", busy, 0);
    check("rst_rxdata", rxdata, 8'h00);
    rst = 1'b0;
    wait_clk(5);

    // Single byte, underrun, abort after 5 bits, reject load while full
    vecs[0] = '{8, 8'h3C, 1'b1, 8'hA5, 1'b0, 8'h00, 1, 8'h3C, 8'hA5};
    vecs[1] = '{8, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 1, 8'hFF, 8'h00};
    vecs[2] = '{5, 8'hAA, 1'b1, 8'hFF, 1'b0, 8'h00, 0, 8'hFF, 8'hF8};
    vecs[3] = '{8, 8'h81, 1'b1, 8'h42, 1'b1, 8'h99, 1, 8'h81, 8'h42};

    for (int v = 0; v < 4; v++) begin
      rx_got.delete();
      if (vecs[v].pre_en) begin
        check("txready_pre", txready, 1);
        do_load(vecs[v].pre);
        wait_clk(1);
        check("txready_full", txready, 0);
      end
      if (vecs[v].pre2_en) do_load(vecs[v].pre2);
      mosi_b[0] = vecs[v].mosi;
      spi_xfer(vecs[v].nbits);
      check("vec_rxvalid_count", rx_got.size(), vecs[v].exp_n);
      if (rx_got.size() > 0) check("vec_rx_byte", rx_got[0], vecs[v].exp_rx);
      check("vec_rxdata", rxdata, vecs[v].exp_rx);
      check("vec_miso_byte", miso_b[0], vecs[v].exp_miso);
      check("vec_txready_after", txready, 1);
    end

    // Back-to-back bytes under one SS, second byte reloaded mid-transfer
    rx_got.delete();
    do_load(8'h11);
    mosi_b[0] = 8'h5A; mosi_b[1] = 8'hC3;
    rel_en[0] = 1'b1; rel_val[0] = 8'h22;
    spi_xfer(16);
    rel_en[0] = 1'b0;
    check("b2b_count", rx_got.size(), 2);
    if (rx_got.size() == 2) begin
      check("b2b_rx0", rx_got[0], 8'h5A);
      check("b2b_rx1", rx_got[1], 8'hC3);
    end
    check("b2b_miso0", miso_b[0], 8'h11);
    check("b2b_miso1", miso_b[1], 8'h22);

    // Reset mid-byte with SS held low and SCLK still toggling
    rx_got.delete();
    ss = 1'b0;
    wait_clk(HALF);
    for (int h = 0; h < 30; h++) begin
      sclk = ~sclk;
      mosi = 1'($urandom_range(0, 1));
      if (h == 5) begin
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(HALF - 3);
      end else begin
        wait_clk(HALF);
      end
    end
    check("rstmid_no_rxvalid", rx_got.size(), 0);
    check("rstmid_miso", miso, 0);
    check("rstmid_rxdata", rxdata, 8'h00);
    check("rstmid_txready", txready, 1);
    ss = 1'b1;
    wait_clk(HALF);
    mosi_b[0] = 8'h81;
    spi_xfer(8);
    check("rstmid_next_count", rx_got.size(), 1);
    if (rx_got.size() > 0) check("rstmid_next_rx", rx_got[0], 8'h81);
    check("rstmid_next_miso", miso_b[0], 8'h00);

    // Random transfers against a byte-level reference model of the holding register
    hf = 1'b0;
    hv = 8'h00;
    for (int it = 0; it < 16; it++) begin
      int         nby, nbits, ncons, na;
      logic [7:0] exp_m[4];
      nby   = $urandom_range(1, 3);
      nbits = nby * 8;
      if ($urandom_range(0, 3) == 0) nbits = $urandom_range(1, nby * 8 - 1);
      for (int k = 0; k < 4; k++) begin
        mosi_b[k]  = 8'($urandom);
        rel_en[k]  = 1'($urandom_range(0, 1));
        rel_val[k] = 8'($urandom);
        exp_m[k]   = 8'h00;
      end
      na = $urandom_range(0, 2);
      for (int a = 0; a < na; a++) begin
        logic [7:0] v;
        v = 8'($urandom);
        check("rand_txready_pre", txready, {31'd0, !hf});
        do_load(v);
        if (!hf) begin
          hf = 1'b1;
          hv = v;
        end
      end
      rx_got.delete();
      spi_xfer(nbits);

      // The holding register is consumed at SS fall and after every completed byte.
      ncons = nbits / 8;
      for (int k = 0; k <= ncons; k++) begin
        logic [7:0] cur;
        int         got;
        cur = hf ? hv : 8'h00;
        hf  = 1'b0;
        if (k * 8 < nbits) begin
          got = nbits - k * 8;
          if (got > 8) got = 8;
          exp_m[k] = cur & (8'hFF << (8 - got));
          if (rel_en[k]) begin
            hf = 1'b1;
            hv = rel_val[k];
          end
        end
      end

      check("rand_rx_count", rx_got.size(), nbits / 8);
      for (int k = 0; k < nbits / 8 && k < rx_got.size(); k++)
        check("rand_rx_byte", rx_got[k], mosi_b[k]);
      for (int k = 0; k < nby; k++) check("rand_miso_byte", miso_b[k], exp_m[k]);
      check("rand_txready_post", txready, {31'd0, !hf});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
